// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Serial frame receiver fed by a 4-bit SISO shift register (one bit per clock).
// Each frame is: start bit (1), DATA_W data bits MSB first, an even-parity bit
// and a stop bit (0). The frame is DATA_W+3 bits long. Received words are
// presented on a single-slot valid/ready output.
//
// Ports:
//   clk         rising-edge clock, one serial bit sampled per edge
//   rst         asynchronous active-low reset
//   sin         serial bit stream, idle level 0
//   dout        received word
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout on an edge where valid && ready
//   parity_err  parity status of the word on dout, qualified by dout_valid
//   frame_err   one-cycle pulse: stop bit was 1, frame discarded
//   overrun     one-cycle pulse: good frame dropped because the slot was full
//
// All outputs come straight from flops; there is no combinational path from
// sin or dout_ready to any output.
// -----------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    // Counter must be able to hold DATA_W itself without wrapping.
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Returns 1 when the word plus its parity bit has an odd number of ones,
    // i.e. the even-parity check fails.
    function automatic logic parity_fail(input logic [DATA_W-1:0] word,
                                         input logic              pbit);
        return (^word) ^ pbit;
    endfunction

    logic [1:0]        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic              par_bit_q,    par_bit_d;
    logic [DATA_W-1:0] dout_q,       dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q,  frame_err_d;
    logic              overrun_q,    overrun_d;

    logic              accept_s;
    logic              slot_free_s;

    // Handshake terms: the slot can take a new word if it is empty now or is
    // being emptied on this very edge.
    always_comb begin
        accept_s    = dout_valid_q & dout_ready;
        slot_free_s = (~dout_valid_q) | accept_s;
    end

    // Next-state logic for the frame FSM and the output slot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        // A consumed word empties the slot unless a new word lands below.
        if (accept_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Only a 1 on the line starts a frame; this is also the sole
                // resynchronisation point after any error.
                if (sin) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                // MSB arrives first, so shifting left leaves it at the top.
                shift_d = {shift_q[DATA_W-2:0], sin};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_PARITY;
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_PARITY: begin
                par_bit_d = sin;
                state_d   = ST_STOP;
            end

            ST_STOP: begin
                state_d = ST_IDLE;
                if (!sin) begin
                    if (slot_free_s) begin
                        dout_d       = shift_q;
                        parity_err_d = parity_fail(shift_q, par_bit_q);
                        dout_valid_d = 1'b1;
                    end else begin
                        // Old word is still pending: keep it, drop the new one.
                        overrun_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
